shreg_loader: RTL and testbench
===============================

Name: shreg_loader

Overview:
Upstream feeder for the 1600-bit serial shift register. Accepts parallel words over a valid/ready handshake and serializes them MSB-first, one bit per enabled cycle, onto the register's shreg_in/shreg_enable inputs. Counts the bits it has pushed and stops when the register is exactly filled, so word 0's MSB arrives at the register output first. Sits between the configuration/bus-side word source and the shift register.

Parameters:
WORD_W, 32, width of each input word; DEPTH must be a multiple of WORD_W (1600/32 = 50 words)
DEPTH, 1600, shift-register length in bits; matches the downstream register size
CNT_W, 11, width of fill_count; must satisfy 2**CNT_W > DEPTH

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset, synchronous, active-low
clear  input  1  synchronous restart pulse: returns to IDLE, fill_count to 0
in_valid  input  1  input word valid
in_ready  output  1  loader can accept a word this cycle
in_data  input  WORD_W  input word; bit WORD_W-1 is shifted first
shreg_enable  output  1  registered; drives the shift register's enable
shreg_in  output  1  registered; serial data bit to the shift register
fill_count  output  CNT_W  registered; bits pushed since reset/clear (0..DEPTH)
busy  output  1  high while in SHIFT
full  output  1  high in DONE; fill_count == DEPTH

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; shreg_enable=0, shreg_in=0, fill_count=0, busy=0, full=0, hold register=0, bit counter=0. Reset wins over clear and every other input.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into hold, set bitcnt=WORD_W-1, go to SHIFT. A word accepted at edge N gives its first bit at shreg_in/shreg_enable after edge N+1 (1-cycle latency).
- SHIFT: each cycle register shreg_enable=1 and shreg_in=hold[WORD_W-1]; shift hold left by 1; decrement bitcnt; increment fill_count.
- Last bit of a word (bitcnt==0):
  - If fill_count+1 == DEPTH, go to DONE.
  - Otherwise in_ready=1 in that same cycle. If in_valid, load the next word and stay in SHIFT with no bubble (back-to-back words give continuous enable). If not, go to IDLE.
- in_ready is combinational from state/bitcnt/fill_count and never depends on in_valid. It is 0 in SHIFT except on the last-bit cycle, and always 0 in DONE.
- Cycles with no pending bit: shreg_enable=0; shreg_in holds its last value.
- DONE: full=1, shreg_enable=0, in_valid ignored. Stays in DONE until clear or reset.
- clear==1 (rst high): next state IDLE, fill_count=0, full=0, busy=0, shreg_enable=0. Any partially shifted word is abandoned and a same-cycle handshake is not accepted. Bits already pushed into the shift register stay there; the loader does not clear it.
- fill_count never exceeds DEPTH and never wraps.
- Concurrent clear and in_valid in IDLE: clear takes priority and in_ready is 0 while clear is high.

Decomposition:
- Shared package shreg_pkg holds:
  - constants SHREG_DEPTH=1600 and SHREG_WORD_W=32
  - the state enum {IDLE, SHIFT, DONE}
  - the CNT_W derivation
- One natural sub-module, shreg_piso: WORD_W parallel-in/serial-out hold register with load, shift, and bit counter. It outputs a last_bit flag; shreg_loader keeps the FSM, handshake and fill counting.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release → in_ready=1, shreg_enable=0, fill_count=0, full=0, busy=0.
- Single word 0xA5000001 accepted at edge N → shreg_enable high for exactly 32 cycles starting after N+1; shreg_in sequence 1,0,1,0,0,1,0,1, then 23 zeros, then 1; then IDLE with fill_count=32.
- Two words 0xFFFFFFFF and 0x00000000 with in_valid continuously high → 64 consecutive enable cycles with no gap (32 ones then 32 zeros); in_ready pulses only on each last-bit cycle.
- 50 words streamed, with in_valid gaps inserted randomly → full rises one cycle after the 1600th bit; fill_count=1600; a 51st in_valid is never accepted. Checked with the real shift register attached: shreg_out shows word 0's MSB.
- clear asserted on the 10th bit of word 3 → next cycle state IDLE, fill_count=0, shreg_enable=0, in_ready=1; the next word starts cleanly at bit 31.
- rst=0 asserted mid-SHIFT concurrently with clear and in_valid → all outputs at reset values on the next edge; no bit emitted after reset.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared constants and FSM state type for the 1600-bit shift-register loader.
package shreg_pkg;

  localparam int SHREG_DEPTH  = 1600;
  localparam int SHREG_WORD_W = 32;
  // Wide enough to hold DEPTH itself (fill_count saturates at DEPTH).
  localparam int SHREG_CNT_W  = $clog2(SHREG_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shreg_state_t;

  // Bit-counter width for a word of w bits; at least 1 bit.
  function automatic int bitcnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shreg_piso.sv
// Parallel-in/serial-out hold register: MSB-first, with a down-counter that
// flags the cycle in which the last bit of the word is presented.
module shreg_piso
  import shreg_pkg::*;
#(
  parameter int WORD_W = SHREG_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              msb,
  output logic              last_bit
);

  localparam int BC_W = bitcnt_w(WORD_W);

  logic [WORD_W-1:0] hold;
  logic [BC_W-1:0]   bitcnt;

  assign msb      = hold[WORD_W-1];
  assign last_bit = (bitcnt == '0);

  // Load wins over shift so a new word can follow the last bit with no bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold   <= '0;
      bitcnt <= '0;
    end else if (load) begin
      hold   <= data;
      bitcnt <= BC_W'(WORD_W - 1);
    end else if (shift) begin
      hold <= hold << 1;
      if (bitcnt != '0) bitcnt <= bitcnt - BC_W'(1);
    end
  end

endmodule

// File: rtl/shreg_loader.sv
// Serializes handshaked parallel words MSB-first into the downstream shift
// register and stops once exactly DEPTH bits have been pushed.
module shreg_loader
  import shreg_pkg::*;
#(
  parameter int WORD_W = SHREG_WORD_W,
  parameter int DEPTH  = SHREG_DEPTH,
  parameter int CNT_W  = SHREG_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              shreg_enable,
  output logic              shreg_in,
  output logic [CNT_W-1:0]  fill_count,
  output logic              busy,
  output logic              full
);

  shreg_state_t state;
  logic         msb;
  logic         last_bit;
  logic         word_end;
  logic         fill_last;
  logic         accept;
  logic         shift;

  // The bit being pushed this cycle is the final one of the register.
  assign fill_last = (fill_count == CNT_W'(DEPTH - 1));
  assign word_end  = (state == SHIFT) && last_bit;
  assign accept    = in_valid && in_ready;
  assign shift     = (state == SHIFT) && !clear;
  assign busy      = (state == SHIFT);
  assign full      = (state == DONE);

  // Ready in IDLE, or on a last-bit cycle that does not complete the fill.
  always_comb begin
    in_ready = 1'b0;
    if (!clear) in_ready = (state == IDLE) || (word_end && !fill_last);
  end

  shreg_piso #(.WORD_W(WORD_W)) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (shift),
    .data     (in_data),
    .msb      (msb),
    .last_bit (last_bit)
  );

  // Loader FSM: owns the handshake, registered serial outputs and fill count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      shreg_enable <= 1'b0;
      shreg_in     <= 1'b0;
      fill_count   <= '0;
    end else if (clear) begin
      // shreg_in keeps its value; bits already pushed are not recalled.
      state        <= IDLE;
      shreg_enable <= 1'b0;
      fill_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          shreg_enable <= 1'b0;
          if (accept) state <= SHIFT;
        end
        SHIFT: begin
          shreg_enable <= 1'b1;
          shreg_in     <= msb;
          fill_count   <= fill_count + CNT_W'(1);
          if (last_bit) begin
            if (fill_last)   state <= DONE;
            else if (accept) state <= SHIFT;
            else             state <= IDLE;
          end
        end
        DONE: begin
          shreg_enable <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          shreg_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_loader.sv
// Randomized bench for shreg_loader against a bit-queue reference model, with
// a behavioural 1600-bit shift register attached to the serial outputs.
module tb_shreg_loader;
  import shreg_pkg::*;

  localparam int W = SHREG_WORD_W;
  localparam int D = SHREG_DEPTH;
  localparam int C = SHREG_CNT_W;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         shreg_enable;
  logic         shreg_in;
  logic [C-1:0] fill_count;
  logic         busy;
  logic         full;

  shreg_loader dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .shreg_enable (shreg_enable),
    .shreg_in     (shreg_in),
    .fill_count   (fill_count),
    .busy         (busy),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register: sr[D-1] is the output end (oldest bit).
  logic [D-1:0] sr;
  always @(posedge clk) if (shreg_enable === 1'b1) sr <= {sr[D-2:0], shreg_in};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bits accepted but not yet emitted, bits emitted, filled.
  bit   m_pend[$];
  int   m_cnt   = 0;
  bit   m_done  = 0;
  bit   m_en    = 0;
  bit   m_in    = 0;
  bit   armed   = 0;
  bit   took    = 0;

  function automatic bit m_ready(input bit cv);
    return !cv && !m_done && (m_pend.size() <= 1) && (m_cnt + m_pend.size() < D);
  endfunction

  task automatic m_edge(input bit vv, input logic [W-1:0] dv, input bit cv, input bit rv,
                        input bit rdy);
    if (!rv) begin
      m_pend.delete(); m_cnt = 0; m_done = 0; m_en = 0; m_in = 0; armed = 1;
    end else if (cv) begin
      m_pend.delete(); m_cnt = 0; m_done = 0; m_en = 0;
    end else begin
      if (m_pend.size() > 0) begin
        m_en = 1; m_in = m_pend.pop_front(); m_cnt++;
        if (m_cnt == D) m_done = 1;
      end else begin
        m_en = 0;
      end
      if (vv && rdy) for (int i = W - 1; i >= 0; i--) m_pend.push_back(dv[i]);
    end
  endtask

  // One clock: drive, check at the falling edge, then advance the model.
  task automatic cyc(input bit vv, input logic [W-1:0] dv, input bit cv, input bit rv);
    bit rdy;
    rst = rv; clear = cv; in_valid = vv; in_data = dv;
    @(negedge clk);
    rdy = m_ready(cv);
    if (armed) begin
      chk("in_ready", in_ready, rdy);
      chk("enable", shreg_enable, m_en);
      chk("shreg_in", shreg_in, m_in);
      chk("fill_count", fill_count, m_cnt);
      chk("busy", busy, m_pend.size() > 0);
      chk("full", full, m_done);
    end
    took = vv && (in_ready === 1'b1);
    @(posedge clk);
    m_edge(vv, dv, cv, rv, rdy);
    #1;
  endtask

  logic [W-1:0] words [0:63];

  task automatic stream(input int n, input int gap_pct);
    int idx = 0;
    int g   = 0;
    while (idx < n && g < 5000) begin
      cyc($urandom_range(99) >= gap_pct, words[idx], 0, 1);
      if (took) idx++;
      g++;
    end
    chk("stream_words", idx, n);
  endtask

  task automatic flush();
    int g = 0;
    while (m_pend.size() > 0 && g < 200) begin
      cyc(0, '0, 0, 1);
      g++;
    end
    chk("flush", m_pend.size(), 0);
  endtask

  initial begin
    int g;
    rst = 0; clear = 0; in_valid = 0; in_data = '0;

    // Reset held three cycles, then idle.
    repeat (3) cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_fill", fill_count, 0);
    repeat (2) cyc(0, '0, 0, 1);

    // Single word, MSB first.
    words[0] = 32'hA500_0001;
    stream(1, 0);
    flush();
    cyc(0, '0, 0, 1);
    chk("single_fill", fill_count, 32);
    chk("single_last", shreg_in, 1);

    // Two words back to back: continuous enable.
    cyc(0, '0, 1, 1);
    words[0] = 32'hFFFF_FFFF;
    words[1] = 32'h0000_0000;
    stream(2, 0);
    flush();
    chk("pair_fill", fill_count, 64);

    // Full fill with random gaps; 51st word must be refused.
    cyc(0, '0, 1, 1);
    for (int i = 0; i < 50; i++) words[i] = $urandom;
    stream(50, 30);
    flush();
    cyc(0, '0, 0, 1);
    chk("fill_count_full", fill_count, D);
    chk("full_flag", full, 1);
    for (int i = 0; i < 20; i++) cyc(1, $urandom, 0, 1);
    chk("no_wrap", fill_count, D);
    chk("sr_out", sr[D-1], words[0][W-1]);
    for (int i = 0; i < 50; i++) chk("sr_word", sr[D-1-W*i -: W], words[i]);

    // Clear on the 10th bit of word 3, then a clean restart.
    cyc(0, '0, 1, 1);
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    stream(4, 0);
    g = 0;
    while (m_cnt != 3 * W + 9 && g < 200) begin
      cyc(0, '0, 0, 1);
      g++;
    end
    chk("reach_bit10", m_cnt, 3 * W + 9);
    cyc(1, $urandom, 1, 1);
    clear = 0; in_valid = 0;
    #1;
    chk("clr_fill", fill_count, 0);
    chk("clr_enable", shreg_enable, 0);
    chk("clr_ready", in_ready, 1);
    chk("clr_busy", busy, 0);
    words[0] = 32'h8000_0000;
    stream(1, 0);
    flush();
    chk("restart_fill", fill_count, 32);

    // Reset mid-shift together with clear and in_valid.
    words[0] = 32'hFFFF_FFFF;
    stream(1, 0);
    repeat (5) cyc(0, '0, 0, 1);
    cyc(1, 32'hFFFF_FFFF, 1, 0);
    chk("mid_rst_en", shreg_enable, 0);
    chk("mid_rst_in", shreg_in, 0);
    chk("mid_rst_fill", fill_count, 0);
    repeat (40) cyc(0, '0, 0, 1);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(99) < 70, $urandom,
          $urandom_range(999) == 0, $urandom_range(1999) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
